// File: rtl/matrix_rx.sv
// rtl/matrix_rx.sv - LED-matrix six-wire link receiver: rebuilds the 16x16 frame and extracts the ball.
module matrix_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rclk,
  input  logic        rsdi,
  input  logic        oeb,
  input  logic        csdi,
  input  logic        cclk,
  input  logic        le,
  input  logic [3:0]  rd_y,
  output logic [15:0] rd_row,
  output logic        frame_done,
  output logic        ball_valid,
  output logic [3:0]  ball_x,
  output logic [3:0]  ball_y,
  output logic        row_err
);

  // Pin vector order {le, cclk, csdi, oeb, rsdi, rclk}; idle has only oeb high.
  localparam logic [5:0] IDLE = 6'b000100;

  logic [5:0]  pins;
  logic [5:0]  sync_q [SYNC_STAGES];
  logic [5:0]  s;
  logic [3:0]  prev_q;
  logic        rclk_ev, cclk_ev, le_ev, oeb_ev;

  logic [15:0] row_sr_q, row_sr_d;
  logic [15:0] col_sr_q, col_sr_d;
  logic [15:0] col_lat_q, col_lat_d;
  logic [15:0] frame_q [16];
  logic [1:0]  pix_cnt_q, pix_cnt_d;
  logic [3:0]  cand_x_q, cand_x_d, cand_y_q, cand_y_d;
  logic        ball_valid_q, ball_valid_d;
  logic [3:0]  ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic        frame_done_q, frame_done_d;
  logic        row_err_q, row_err_d;
  logic [15:0] rd_row_q;

  logic        onehot, commit_ok;
  logic [3:0]  commit_y, pix_x;
  logic [4:0]  pc, sum;
  logic [1:0]  pix_sat;

  assign pins = {le, cclk, csdi, oeb, rsdi, rclk};
  assign s    = sync_q[SYNC_STAGES-1];

  assign rclk_ev = s[0] & ~prev_q[0];
  assign oeb_ev  = ~s[2] & prev_q[1];
  assign cclk_ev = s[4] & ~prev_q[2];
  assign le_ev   = s[5] & ~prev_q[3];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= IDLE;
      prev_q <= {IDLE[5], IDLE[4], IDLE[2], IDLE[0]};
    end else begin
      sync_q[0] <= pins;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      prev_q <= {s[5], s[4], s[2], s[0]};
    end
  end

  always_comb begin
    row_sr_d  = rclk_ev ? {row_sr_q[14:0], s[1]} : row_sr_q;
    col_sr_d  = cclk_ev ? {col_sr_q[14:0], s[3]} : col_sr_q;
    // Latch takes the pre-shift word; a same-cycle commit sees the new latch value.
    col_lat_d = le_ev ? col_sr_q : col_lat_q;

    onehot   = (row_sr_q != 16'd0) && ((row_sr_q & (row_sr_q - 16'd1)) == 16'd0);
    commit_y = 4'd0;
    for (int i = 0; i < 16; i++) if (row_sr_q[i]) commit_y = 4'(i);

    pc    = 5'd0;
    pix_x = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (col_lat_d[i]) begin
        pc    = pc + 5'd1;
        pix_x = 4'(i);
      end
    end
    sum     = {3'd0, pix_cnt_q} + pc;
    pix_sat = (sum >= 5'd2) ? 2'd2 : sum[1:0];

    commit_ok    = oeb_ev && onehot;
    pix_cnt_d    = pix_cnt_q;
    cand_x_d     = cand_x_q;
    cand_y_d     = cand_y_q;
    ball_valid_d = ball_valid_q;
    ball_x_d     = ball_x_q;
    ball_y_d     = ball_y_q;
    frame_done_d = 1'b0;
    row_err_d    = oeb_ev && !onehot;

    if (commit_ok) begin
      pix_cnt_d = pix_sat;
      if (pc == 5'd1) begin
        cand_x_d = pix_x;
        cand_y_d = commit_y;
      end
      if (commit_y == 4'd15) begin
        ball_valid_d = (pix_sat == 2'd1);
        if (pix_sat == 2'd1) begin
          ball_x_d = cand_x_d;
          ball_y_d = cand_y_d;
        end
        frame_done_d = 1'b1;
        pix_cnt_d    = 2'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_sr_q     <= 16'd0;
      col_sr_q     <= 16'd0;
      col_lat_q    <= 16'd0;
      for (int r = 0; r < 16; r++) frame_q[r] <= 16'd0;
      pix_cnt_q    <= 2'd0;
      cand_x_q     <= 4'd0;
      cand_y_q     <= 4'd0;
      ball_valid_q <= 1'b0;
      ball_x_q     <= 4'd0;
      ball_y_q     <= 4'd0;
      frame_done_q <= 1'b0;
      row_err_q    <= 1'b0;
      rd_row_q     <= 16'd0;
    end else begin
      row_sr_q     <= row_sr_d;
      col_sr_q     <= col_sr_d;
      col_lat_q    <= col_lat_d;
      if (commit_ok) frame_q[commit_y] <= col_lat_d;
      pix_cnt_q    <= pix_cnt_d;
      cand_x_q     <= cand_x_d;
      cand_y_q     <= cand_y_d;
      ball_valid_q <= ball_valid_d;
      ball_x_q     <= ball_x_d;
      ball_y_q     <= ball_y_d;
      frame_done_q <= frame_done_d;
      row_err_q    <= row_err_d;
      rd_row_q     <= frame_q[rd_y];
    end
  end

  assign rd_row     = rd_row_q;
  assign frame_done = frame_done_q;
  assign ball_valid = ball_valid_q;
  assign ball_x     = ball_x_q;
  assign ball_y     = ball_y_q;
  assign row_err    = row_err_q;

endmodule

// File: tb/tb_matrix_rx.sv
// tb/tb_matrix_rx.sv - directed and randomized checks of matrix_rx against a frame/pixel-list model.
module tb_matrix_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic        rclk, rsdi, oeb, csdi, cclk, le;
  logic [3:0]  rd_y;
  logic [15:0] rd_row;
  logic        frame_done, ball_valid, row_err;
  logic [3:0]  ball_x, ball_y;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;
  int re_cnt = 0;

  logic [15:0] mframe [16];
  logic [7:0]  pix_q [$];
  logic        exp_bv;
  logic [3:0]  exp_bx, exp_by;

  matrix_rx #(.SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .rclk(rclk), .rsdi(rsdi), .oeb(oeb), .csdi(csdi),
    .cclk(cclk), .le(le), .rd_y(rd_y), .rd_row(rd_row), .frame_done(frame_done),
    .ball_valid(ball_valid), .ball_x(ball_x), .ball_y(ball_y), .row_err(row_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_cnt++;
    if (row_err === 1'b1) re_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_idle();
    rclk = 0; rsdi = 0; oeb = 1; csdi = 0; cclk = 0; le = 0;
  endtask

  task automatic shift_bits(input logic [15:0] rv, input logic [15:0] cv);
    for (int i = 15; i >= 0; i--) begin
      rsdi = rv[i]; csdi = cv[i];
      tick(2);
      rclk = 1; cclk = 1;
      tick(3);
      rclk = 0; cclk = 0;
      tick(2);
    end
    rsdi = 0; csdi = 0;
  endtask

  task automatic pulse_le();
    le = 1; tick(3); le = 0; tick(3);
  endtask

  task automatic pulse_oeb();
    oeb = 0; tick(3); oeb = 1; tick(3); tick(2);
  endtask

  task automatic model_reset();
    for (int r = 0; r < 16; r++) mframe[r] = 16'd0;
    pix_q.delete();
    exp_bv = 0; exp_bx = 0; exp_by = 0;
  endtask

  // Model: a one-hot row vector stores the latched word; every lit pixel of an
  // accepted commit joins the frame's pixel list; row 15 closes the frame.
  task automatic apply_and_check(input logic [15:0] rv, input logic [15:0] w,
                                 input int fd0, input int re0);
    bit ok, fin;
    int y;
    ok = ($countones(rv) == 1);
    fin = 0;
    y = 0;
    if (ok) begin
      for (int i = 0; i < 16; i++) if (rv[i]) y = i;
      mframe[y] = w;
      for (int x = 0; x < 16; x++) if (w[x]) pix_q.push_back({4'(x), 4'(y)});
      if (y == 15) begin
        fin = 1;
        if (pix_q.size() == 1) begin
          exp_bv = 1; exp_bx = pix_q[0][7:4]; exp_by = pix_q[0][3:0];
        end else begin
          exp_bv = 0;
        end
        pix_q.delete();
      end
    end
    check("row_err_pulses", 32'(re_cnt - re0), ok ? 32'd0 : 32'd1);
    check("frame_done_pulses", 32'(fd_cnt - fd0), fin ? 32'd1 : 32'd0);
    check("ball_valid", 32'(ball_valid), 32'(exp_bv));
    check("ball_x", 32'(ball_x), 32'(exp_bx));
    check("ball_y", 32'(ball_y), 32'(exp_by));
  endtask

  task automatic commit(input logic [15:0] rv, input logic [15:0] w);
    int fd0, re0;
    shift_bits(rv, w);
    pulse_le();
    fd0 = fd_cnt; re0 = re_cnt;
    pulse_oeb();
    apply_and_check(rv, w, fd0, re0);
  endtask

  task automatic read_row(input logic [3:0] y, output logic [15:0] d);
    rd_y = y;
    tick(1);
    d = rd_row;
  endtask

  task automatic check_all_rows();
    logic [15:0] d;
    for (int r = 0; r < 16; r++) begin
      read_row(4'(r), d);
      check($sformatf("rd_row[%0d]", r), 32'(d), 32'(mframe[r]));
    end
  endtask

  task automatic check_outputs_zero();
    check("rst_rd_row", 32'(rd_row), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_ball_valid", 32'(ball_valid), 32'd0);
    check("rst_ball_x", 32'(ball_x), 32'd0);
    check("rst_ball_y", 32'(ball_y), 32'd0);
    check("rst_row_err", 32'(row_err), 32'd0);
  endtask

  initial begin
    logic [15:0] d;
    int fd0, re0;
    reset = 1; rd_y = 0;
    set_idle();
    model_reset();

    // Reset held while every input toggles.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      {rclk, rsdi, oeb, csdi, cclk, le} = 6'($urandom);
      rd_y = 4'($urandom);
    end
    set_idle();
    check_outputs_zero();
    tick(1);
    reset = 0;
    fd0 = fd_cnt; re0 = re_cnt;
    tick(8);
    check("idle_frame_done", 32'(fd_cnt - fd0), 32'd0);
    check("idle_row_err", 32'(re_cnt - re0), 32'd0);
    check_all_rows();

    // Single row, then close the frame.
    commit(16'h0008, 16'hA5C3);
    read_row(4'd3, d);
    check("single_row3", 32'(d), 32'h0000A5C3);
    commit(16'h8000, 16'h0000);

    // Ball frame, then the same with a second pixel.
    for (int y = 0; y < 16; y++) commit(16'h0001 << y, (y == 6) ? 16'h0200 : 16'h0000);
    check("ball_frame_x", 32'(ball_x), 32'd9);
    check("ball_frame_y", 32'(ball_y), 32'd6);
    check("ball_frame_v", 32'(ball_valid), 32'd1);
    for (int y = 0; y < 16; y++)
      commit(16'h0001 << y, (y == 6) ? 16'h0200 : ((y == 12) ? 16'h0001 : 16'h0000));
    check("two_pix_v", 32'(ball_valid), 32'd0);
    check("two_pix_x", 32'(ball_x), 32'd9);
    check("two_pix_y", 32'(ball_y), 32'd6);
    check_all_rows();

    // A repeated single-pixel row counts twice.
    commit(16'h0010, 16'h0010);
    commit(16'h0010, 16'h0010);
    commit(16'h8000, 16'h0000);

    // Randomized frames with skipped and repeated rows.
    for (int f = 0; f < 5; f++) begin
      int n, bi, ei;
      logic [3:0] bx;
      bit extra;
      n = $urandom_range(3, 6);
      bi = $urandom_range(0, n - 1);
      ei = $urandom_range(0, n - 1);
      bx = 4'($urandom_range(0, 15));
      extra = ($urandom_range(0, 1) == 1);
      for (int i = 0; i < n; i++) begin
        logic [15:0] w;
        int y;
        y = $urandom_range(0, 14);
        w = 16'd0;
        if (i == bi) w[bx] = 1'b1;
        if (extra && i == ei) w = w | 16'($urandom);
        commit(16'h0001 << y, w);
      end
      commit(16'h8000, 16'h0000);
      check_all_rows();
    end

    // Rejected commits: two bits set, then none.
    commit(16'h0011, 16'hFFFF);
    commit(16'h0000, 16'h1234);
    check_all_rows();

    // le rise and oeb fall in the same sampled cycle.
    shift_bits(16'h0020, 16'h3C5A);
    fd0 = fd_cnt; re0 = re_cnt;
    le = 1; oeb = 0;
    tick(3);
    le = 0; oeb = 1;
    tick(5);
    apply_and_check(16'h0020, 16'h3C5A, fd0, re0);
    read_row(4'd5, d);
    check("latch_commit_fwd", 32'(d), 32'h00003C5A);

    // cclk and le together: latch keeps the pre-shift word.
    shift_bits(16'h0080, 16'h8E71);
    csdi = 1;
    tick(2);
    cclk = 1; le = 1;
    tick(3);
    cclk = 0; le = 0;
    tick(3);
    csdi = 0;
    fd0 = fd_cnt; re0 = re_cnt;
    pulse_oeb();
    apply_and_check(16'h0080, 16'h8E71, fd0, re0);
    read_row(4'd7, d);
    check("shift_latch_pre", 32'(d), 32'h00008E71);

    // Reset after 7 of 16 column shifts.
    for (int i = 0; i < 7; i++) begin
      csdi = 1'($urandom);
      tick(2); cclk = 1; tick(3); cclk = 0; tick(2);
    end
    reset = 1;
    tick(3);
    set_idle();
    check_outputs_zero();
    tick(1);
    reset = 0;
    model_reset();
    fd0 = fd_cnt; re0 = re_cnt;
    tick(8);
    check("post_rst_frame_done", 32'(fd_cnt - fd0), 32'd0);
    check("post_rst_row_err", 32'(re_cnt - re0), 32'd0);
    check_all_rows();
    fd0 = fd_cnt; re0 = re_cnt;
    pulse_le();
    pulse_oeb();
    apply_and_check(16'h0000, 16'h0000, fd0, re0);
    check_all_rows();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
